// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard inputs and pipeline control/status outputs.
// Purely wiring; no latency of its own.
// No flow control; the hazard unit's outputs are its backpressure to the pipeline.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // Pipeline-side observations
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [3:0]            ex_MemRead;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_redirect;
  logic                  mem_access;
  logic                  mem_ready;

  // Hazard-unit decisions and status
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  control_MUX_select;
  logic                  exmem_write;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  // Pipeline side: supplies observations, consumes decisions
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
           ex_redirect, mem_access, mem_ready,
    input  pc_write, ifid_write, ifid_flush, control_MUX_select, exmem_write,
           mem_timeout, stall_cycles, flush_count
  );

  // Hazard unit side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
           ex_redirect, mem_access, mem_ready,
    output pc_write, ifid_write, ifid_flush, control_MUX_select, exmem_write,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, data-memory freeze.
// Control outputs are combinational (zero latency); counters/flag update at the next edge.
// Freezes the whole pipeline while memory is not ready, bounded by MEM_TIMEOUT cycles.
module hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz
);

  // wcnt counts frozen cycles already spent on the current access
  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Value of wcnt at which the current frozen cycle is the last one allowed
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t            st_q, st_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              tout_q, tout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic freeze;
  logic lu;
  logic rs1_hit;
  logic rs2_hit;

  // Hazard condition terms
  always_comb begin
    rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    lu      = (hz.ex_MemRead != 4'd0) && (hz.ex_rd != '0) && (rs1_hit || rs2_hit);
    // RELEASE never freezes so an abandoned access can leave MEM
    freeze  = ((st_q == MEM_WAIT) && !hz.mem_ready) ||
              ((st_q == RUN) && hz.mem_access && !hz.mem_ready);
  end

  // Prioritised control outputs: freeze > redirect > load-use > normal
  always_comb begin
    hz.pc_write           = 1'b1;
    hz.ifid_write         = 1'b1;
    hz.ifid_flush         = 1'b0;
    hz.control_MUX_select = 1'b0;
    hz.exmem_write        = 1'b1;
    if (!rst_n) begin
      // Hold the pipeline with a bubble while reset is asserted
      hz.pc_write           = 1'b0;
      hz.ifid_write         = 1'b0;
      hz.exmem_write        = 1'b0;
      hz.ifid_flush         = 1'b1;
      hz.control_MUX_select = 1'b1;
    end else if (freeze) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.exmem_write = 1'b0;
    end else if (hz.ex_redirect) begin
      hz.ifid_flush         = 1'b1;
      hz.control_MUX_select = 1'b1;
    end else if (lu) begin
      // One bubble; next cycle the bubble sits in EX so lu clears itself
      hz.pc_write           = 1'b0;
      hz.ifid_write         = 1'b0;
      hz.control_MUX_select = 1'b1;
    end
  end

  // Memory-wait state machine: next state, wait count, timeout flag
  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    tout_d = tout_q;
    unique case (st_q)
      RUN: begin
        if (freeze) begin
          // Entry cycle is itself the first frozen cycle
          if (WLAST == '0) begin
            st_d   = RELEASE;
            wcnt_d = '0;
            tout_d = 1'b1;
          end else begin
            st_d   = MEM_WAIT;
            wcnt_d = WCNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          st_d   = RUN;
          wcnt_d = '0;
        end else if (wcnt_q >= WLAST) begin
          st_d   = RELEASE;
          wcnt_d = '0;
          tout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      RELEASE: begin
        st_d   = RUN;
        wcnt_d = '0;
      end
      default: begin
        st_d   = RUN;
        wcnt_d = '0;
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((freeze || (lu && !hz.ex_redirect)) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    if (!freeze && hz.ex_redirect && (flush_q != {CNT_W{1'b1}}))
      flush_d = flush_q + CNT_W'(1);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= RUN;
      wcnt_q  <= '0;
      tout_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      tout_q  <= tout_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Status outputs
  always_comb begin
    hz.mem_timeout  = tout_q;
    hz.stall_cycles = stall_q;
    hz.flush_count  = flush_q;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic against a reference model.
// Driver pushes expected per-cycle responses; a negedge monitor pops and compares.
// Small counter width so saturation is reachable.
module tb_hazard_unit;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int MT   = 15;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hz ();

  hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    bit pcw, ifw, fl, cms, exw, tout;
    int stall, flush;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: "waiting on memory", length of current freeze, release pending
  bit m_wait, m_rel, m_tout;
  int m_len, m_stall, m_flush;

  task automatic model_reset();
    m_wait = 0; m_rel = 0; m_tout = 0;
    m_len = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic void chk(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, expv);
    end
  endfunction

  // Monitor: outputs are combinational, so sample mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_write",           int'(hz.pc_write),           int'(e.pcw));
      chk("ifid_write",         int'(hz.ifid_write),         int'(e.ifw));
      chk("ifid_flush",         int'(hz.ifid_flush),         int'(e.fl));
      chk("control_MUX_select", int'(hz.control_MUX_select), int'(e.cms));
      chk("exmem_write",        int'(hz.exmem_write),        int'(e.exw));
      chk("mem_timeout",        int'(hz.mem_timeout),        int'(e.tout));
      chk("stall_cycles",       int'(hz.stall_cycles),       e.stall);
      chk("flush_count",        int'(hz.flush_count),        e.flush);
    end
  end

  // One cycle of stimulus; expected response derived from the model and queued
  task automatic cyc(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                     input int mr, input int rd, input bit redir, input bit acc, input bit rdy);
    exp_t e;
    bit frozen, lu;
    @(posedge clk);
    #1;
    rst_n          = r;
    hz.id_rs1      = RW'(rs1);
    hz.id_rs2      = RW'(rs2);
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.ex_MemRead  = 4'(mr);
    hz.ex_rd       = RW'(rd);
    hz.ex_redirect = redir;
    hz.mem_access  = acc;
    hz.mem_ready   = rdy;
    if (!r) begin
      model_reset();
      e = '{pcw: 0, ifw: 0, fl: 1, cms: 1, exw: 0, tout: 0, stall: 0, flush: 0};
    end else begin
      frozen = !m_rel && !rdy && (m_wait || acc);
      lu = (mr != 0) && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (frozen)     e = '{pcw: 0, ifw: 0, fl: 0, cms: 0, exw: 0, tout: 0, stall: 0, flush: 0};
      else if (redir) e = '{pcw: 1, ifw: 1, fl: 1, cms: 1, exw: 1, tout: 0, stall: 0, flush: 0};
      else if (lu)    e = '{pcw: 0, ifw: 0, fl: 0, cms: 1, exw: 1, tout: 0, stall: 0, flush: 0};
      else            e = '{pcw: 1, ifw: 1, fl: 0, cms: 0, exw: 1, tout: 0, stall: 0, flush: 0};
      e.tout  = m_tout;
      e.stall = m_stall;
      e.flush = m_flush;
      if (frozen || (lu && !redir)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (!frozen && redir)         m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (frozen) begin
        m_len++;
        if (m_len == MT) begin
          m_wait = 0; m_rel = 1; m_tout = 1; m_len = 0;
        end else begin
          m_wait = 1;
        end
      end else begin
        m_wait = 0; m_rel = 0; m_len = 0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int hold_lo;
    model_reset();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_MemRead = '0; hz.ex_rd = '0; hz.ex_redirect = 0;
    hz.mem_access = 0; hz.mem_ready = 1;

    // Reset state, then load-use on rs2, then the same with ex_rd = x0
    do_reset();
    cyc(1, 0, 5, 0, 1, 'hF, 5, 0, 0, 1);
    idle(1);
    cyc(1, 0, 0, 0, 1, 'hF, 0, 0, 0, 1);
    cyc(1, 3, 0, 1, 0, 'h1, 3, 0, 0, 1);
    idle(1);

    // Redirect and load-use together
    do_reset();
    cyc(1, 0, 5, 0, 1, 'hF, 5, 1, 0, 1);
    idle(1);

    // Three-cycle memory wait, then a single-cycle access
    do_reset();
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Timeout: MT frozen cycles, one release cycle, then a normal access
    do_reset();
    repeat (MT) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 5, 0, 1, 'hF, 5, 0, 1, 0);
    idle(1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Freeze masks redirect until release
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);

    // Counter saturation, then asynchronous reset in the middle of a wait
    do_reset();
    repeat (20) cyc(1, 7, 0, 1, 0, 'h3, 7, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Random traffic with small register indices to provoke collisions
    hold_lo = 0;
    for (int i = 0; i < 800; i++) begin
      bit rdy, r;
      if (hold_lo == 0 && $urandom_range(0, 39) == 0) hold_lo = $urandom_range(3, 20);
      if (hold_lo > 0) begin
        rdy = 0;
        hold_lo--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      r = ($urandom_range(0, 149) != 0);
      cyc(r, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) != 0) ? $urandom_range(1, 15) : 0,
          $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 2) == 0), rdy);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
